// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch sequencer. It reads one or two 16-bit words from the
// instruction memory at the address supplied by the PC unit. After each word
// is accepted it asks the PC unit to advance by one word. A one-cycle valid
// pulse then marks the latched instruction, and its optional immediate, as
// ready.
//
// Ports
//   clk          in   1   sole clock, rising edge
//   rst          in   1   synchronous active-high reset
//   en           in   1   fetch request, sampled only in IDLE
//   flush        in   1   abort the fetch in flight, return to IDLE
//   pc_in        in  16   current PC from the PC unit
//   mem_data_in  in  16   instruction memory read data
//   mem_ack      in   1   read complete, mem_data_in valid this cycle
//   mem_addr     out 16   read address, a combinational copy of pc_in
//   mem_rd       out  1   read request, high in FETCH1/FETCH2
//   pc_en        out  1   PC unit enable, high in INC1/INC2
//   pc_op        out  2   PC operation (PC_INC in INC1/INC2, else PC_NOP)
//   instr_out    out 16   latched first instruction word
//   imm_out      out 16   latched immediate word
//   has_imm      out  1   bit 8 of the latched instruction word
//   valid        out  1   one-cycle pulse, fetch complete
//   dbg_state_o  out  3   current FSM state, for observation only
//
// Memory handshake: mem_rd is a level request held for as long as the FSM sits
// in a FETCH state. The word is transferred in the cycle where mem_rd and
// mem_ack are both high. mem_ack is ignored in every other cycle. The address
// is not sampled here; the memory sees pc_in directly.
// -----------------------------------------------------------------------------
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic [15:0] pc_in,
  input  logic [15:0] mem_data_in,
  input  logic        mem_ack,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        pc_en,
  output logic [1:0]  pc_op,
  output logic [15:0] instr_out,
  output logic [15:0] imm_out,
  output logic        has_imm,
  output logic        valid,
  output logic [2:0]  dbg_state_o
);

  // PC unit operation encodings, shared with the PC unit.
  localparam logic [1:0] PC_NOP = 2'b00;
  localparam logic [1:0] PC_INC = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH1 = 3'd1,
    S_INC1   = 3'd2,
    S_FETCH2 = 3'd3,
    S_INC2   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] imm_q,   imm_d;
  logic        has_imm_q, has_imm_d;

  // ---------------------------------------------------------------------------
  // State and capture registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      instr_q   <= 16'h0000;
      imm_q     <= 16'h0000;
      has_imm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      imm_q     <= imm_d;
      has_imm_q <= has_imm_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and capture. Flush is checked first in every state. A word that
  // is acknowledged in the same cycle as a flush is therefore dropped, and the
  // latched words keep their old values.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    has_imm_d = has_imm_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (en) state_d = S_FETCH1;
        end
        S_FETCH1: begin
          if (mem_ack) begin
            instr_d   = mem_data_in;
            has_imm_d = mem_data_in[8];
            state_d   = S_INC1;
          end
        end
        S_INC1: begin
          // Use the registered flag captured with the first word.
          state_d = has_imm_q ? S_FETCH2 : S_DONE;
        end
        S_FETCH2: begin
          if (mem_ack) begin
            imm_d   = mem_data_in;
            state_d = S_INC2;
          end
        end
        S_INC2: begin
          state_d = S_DONE;
        end
        S_DONE: begin
          // en is not looked at here. Back-to-back fetches always pass
          // through one IDLE cycle.
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs, decoded from the state register only. A flush in INC1/INC2
  // still lets that cycle's increment through, so the PC stays word-aligned
  // with what was consumed from memory.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_rd = 1'b0;
    pc_en  = 1'b0;
    pc_op  = PC_NOP;
    valid  = 1'b0;
    unique case (state_q)
      S_FETCH1, S_FETCH2: mem_rd = 1'b1;
      S_INC1, S_INC2: begin
        pc_en = 1'b1;
        pc_op = PC_INC;
      end
      S_DONE:  valid = 1'b1;
      default: begin
        mem_rd = 1'b0;
      end
    endcase
  end

  // The address passes straight through. The PC unit does all the
  // arithmetic, so the second word is read from the post-increment PC.
  assign mem_addr    = pc_in;
  assign instr_out   = instr_q;
  assign imm_out     = imm_q;
  assign has_imm     = has_imm_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. The bench plays the PC unit: it adds 2 to
// pc_in after every cycle in which the DUT asserts pc_en with PC_INC. It also
// plays the instruction memory, driving mem_data_in/mem_ack by hand. All
// expected values are written out for each step.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [1:0] PC_NOP = 2'b00;
  localparam logic [1:0] PC_INC = 2'b01;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH1 = 3'd1;
  localparam logic [2:0] ST_INC1   = 3'd2;
  localparam logic [2:0] ST_FETCH2 = 3'd3;
  localparam logic [2:0] ST_INC2   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic        clk;
  logic        rst;
  logic        en;
  logic        flush;
  logic [15:0] pc_in;
  logic [15:0] mem_data_in;
  logic        mem_ack;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        pc_en;
  logic [1:0]  pc_op;
  logic [15:0] instr_out;
  logic [15:0] imm_out;
  logic        has_imm;
  logic        valid;
  logic [2:0]  dbg_state_o;

  int errors;
  int checks;
  int valid_cnt;
  int inc_cnt;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .flush       (flush),
    .pc_in       (pc_in),
    .mem_data_in (mem_data_in),
    .mem_ack     (mem_ack),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .pc_en       (pc_en),
    .pc_op       (pc_op),
    .instr_out   (instr_out),
    .imm_out     (imm_out),
    .has_imm     (has_imm),
    .valid       (valid),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Advance one cycle. Inputs change and outputs are sampled 1 ns after the
  // rising edge. The PC model applies the increment requested in the cycle
  // that just ended.
  task automatic tick();
    logic inc;
    inc = pc_en && (pc_op == PC_INC);
    @(posedge clk);
    #1;
    if (inc) begin
      pc_in   = pc_in + 16'd2;
      inc_cnt = inc_cnt + 1;
    end
    if (valid) valid_cnt = valid_cnt + 1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // State plus all Moore control outputs. pc_op follows pc_en.
  task automatic chk_ctl(input string tag, input logic [2:0] st, input logic rd,
                         input logic pe, input logic vl);
    chk({tag, ".state"}, {13'd0, dbg_state_o}, {13'd0, st});
    chk({tag, ".mem_rd"}, {15'd0, mem_rd}, {15'd0, rd});
    chk({tag, ".pc_en"}, {15'd0, pc_en}, {15'd0, pe});
    chk({tag, ".pc_op"}, {14'd0, pc_op}, {14'd0, (pe ? PC_INC : PC_NOP)});
    chk({tag, ".valid"}, {15'd0, valid}, {15'd0, vl});
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    errors = 0; checks = 0; valid_cnt = 0; inc_cnt = 0;
    rst = 1'b1; en = 1'b0; flush = 1'b0; pc_in = 16'h0000;
    mem_data_in = 16'h0000; mem_ack = 1'b0;

    // Reset, with en/flush/ack all active to show that reset wins.
    en = 1'b1; flush = 1'b1; mem_ack = 1'b1; mem_data_in = 16'hFFFF;
    tick(); tick();
    chk_ctl("reset", ST_IDLE, 1'b0, 1'b0, 1'b0);
    chk("reset.instr", instr_out, 16'h0000);
    chk("reset.imm", imm_out, 16'h0000);
    chk("reset.has_imm", {15'd0, has_imm}, 16'h0000);
    rst = 1'b0; en = 1'b0; flush = 1'b0; mem_ack = 1'b0;

    // Single word: 0x1234 at 0x0000, ack in the first FETCH1 cycle.
    valid_cnt = 0; inc_cnt = 0;
    pc_in = 16'h0000; en = 1'b1; mem_ack = 1'b1; mem_data_in = 16'h1234;
    tick();                                     // cycle 1
    en = 1'b0;
    chk_ctl("sw.c1", ST_FETCH1, 1'b1, 1'b0, 1'b0);
    chk("sw.c1.addr", mem_addr, 16'h0000);
    tick();                                     // cycle 2
    mem_ack = 1'b0;
    chk_ctl("sw.c2", ST_INC1, 1'b0, 1'b1, 1'b0);
    chk("sw.c2.instr", instr_out, 16'h1234);
    chk("sw.c2.has_imm", {15'd0, has_imm}, 16'h0000);
    tick();                                     // cycle 3
    chk_ctl("sw.c3", ST_DONE, 1'b0, 1'b0, 1'b1);
    chk("sw.c3.pc", pc_in, 16'h0002);
    tick();
    chk_ctl("sw.c4", ST_IDLE, 1'b0, 1'b0, 1'b0);
    chk("sw.valid_cnt", valid_cnt[15:0], 16'd1);
    chk("sw.inc_cnt", inc_cnt[15:0], 16'd1);

    // Two words: 0x0100 at 0x0000 and 0xBEEF at 0x0002. The ack is held high
    // through INC1 with 0xBEEF on the bus, and INC1 must ignore it.
    valid_cnt = 0; inc_cnt = 0;
    pc_in = 16'h0000; en = 1'b1; mem_ack = 1'b1; mem_data_in = 16'h0100;
    tick();                                     // cycle 1
    en = 1'b0;
    chk_ctl("tw.c1", ST_FETCH1, 1'b1, 1'b0, 1'b0);
    chk("tw.c1.addr", mem_addr, 16'h0000);
    tick();                                     // cycle 2
    mem_data_in = 16'hBEEF;
    chk_ctl("tw.c2", ST_INC1, 1'b0, 1'b1, 1'b0);
    chk("tw.c2.has_imm", {15'd0, has_imm}, 16'h0001);
    tick();                                     // cycle 3
    chk_ctl("tw.c3", ST_FETCH2, 1'b1, 1'b0, 1'b0);
    chk("tw.c3.addr", mem_addr, 16'h0002);
    chk("tw.c3.instr", instr_out, 16'h0100);
    tick();                                     // cycle 4
    mem_ack = 1'b0;
    chk_ctl("tw.c4", ST_INC2, 1'b0, 1'b1, 1'b0);
    chk("tw.c4.imm", imm_out, 16'hBEEF);
    tick();                                     // cycle 5
    chk_ctl("tw.c5", ST_DONE, 1'b0, 1'b0, 1'b1);
    chk("tw.c5.pc", pc_in, 16'h0004);
    tick();
    chk_ctl("tw.c6", ST_IDLE, 1'b0, 1'b0, 1'b0);
    chk("tw.valid_cnt", valid_cnt[15:0], 16'd1);
    chk("tw.inc_cnt", inc_cnt[15:0], 16'd2);

    // Four wait states in FETCH1: mem_rd high for cycles 1..5, valid at cycle 7.
    valid_cnt = 0; inc_cnt = 0;
    pc_in = 16'h0010; en = 1'b1; mem_ack = 1'b0; mem_data_in = 16'h0042;
    tick();                                     // cycle 1
    en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk_ctl("ws.wait", ST_FETCH1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk_ctl("ws.c5", ST_FETCH1, 1'b1, 1'b0, 1'b0);  // cycle 5, ack now
    chk("ws.c5.inc_cnt", inc_cnt[15:0], 16'd0);
    mem_ack = 1'b1;
    tick();                                     // cycle 6
    mem_ack = 1'b0;
    chk_ctl("ws.c6", ST_INC1, 1'b0, 1'b1, 1'b0);
    tick();                                     // cycle 7
    chk_ctl("ws.c7", ST_DONE, 1'b0, 1'b0, 1'b1);
    chk("ws.instr", instr_out, 16'h0042);
    chk("ws.imm_hold", imm_out, 16'hBEEF);
    chk("ws.pc", pc_in, 16'h0012);
    tick();

    // Flush coincident with the ack in FETCH1: the word is dropped.
    valid_cnt = 0; inc_cnt = 0;
    en = 1'b1;
    tick();
    en = 1'b0;
    chk_ctl("fl.f1", ST_FETCH1, 1'b1, 1'b0, 1'b0);
    flush = 1'b1; mem_ack = 1'b1; mem_data_in = 16'h5555;
    tick();
    flush = 1'b0; mem_ack = 1'b0;
    chk_ctl("fl.idle", ST_IDLE, 1'b0, 1'b0, 1'b0);
    chk("fl.instr", instr_out, 16'h0042);
    chk("fl.has_imm", {15'd0, has_imm}, 16'h0000);
    tick(); tick();
    chk("fl.valid_cnt", valid_cnt[15:0], 16'd0);
    chk("fl.inc_cnt", inc_cnt[15:0], 16'd0);
    chk("fl.pc", pc_in, 16'h0012);

    // Flush during INC1: the increment still happens, and no valid follows
    // even though has_imm is set.
    valid_cnt = 0; inc_cnt = 0;
    en = 1'b1; mem_ack = 1'b1; mem_data_in = 16'h0177;
    tick();
    en = 1'b0;
    tick();
    mem_ack = 1'b0; flush = 1'b1;
    chk_ctl("fi.inc1", ST_INC1, 1'b0, 1'b1, 1'b0);
    tick();
    flush = 1'b0;
    chk_ctl("fi.idle", ST_IDLE, 1'b0, 1'b0, 1'b0);
    chk("fi.instr", instr_out, 16'h0177);
    chk("fi.pc", pc_in, 16'h0014);
    tick(); tick();
    chk("fi.valid_cnt", valid_cnt[15:0], 16'd0);

    // Reset in FETCH2, with an ack present, then a normal fetch.
    valid_cnt = 0; inc_cnt = 0;
    en = 1'b1; mem_ack = 1'b1; mem_data_in = 16'h01AA;
    tick();                                     // FETCH1
    en = 1'b0;
    tick();                                     // INC1
    mem_data_in = 16'h3333;
    tick();                                     // FETCH2
    chk_ctl("rm.f2", ST_FETCH2, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_ack = 1'b0;
    chk_ctl("rm.rst", ST_IDLE, 1'b0, 1'b0, 1'b0);
    chk("rm.instr", instr_out, 16'h0000);
    chk("rm.imm", imm_out, 16'h0000);
    chk("rm.has_imm", {15'd0, has_imm}, 16'h0000);
    tick();
    chk("rm.inc_cnt", inc_cnt[15:0], 16'd1);
    chk("rm.valid_cnt", valid_cnt[15:0], 16'd0);
    pc_in = 16'h0020; en = 1'b1; mem_ack = 1'b1; mem_data_in = 16'h00C3;
    tick();
    en = 1'b0;
    tick();
    mem_ack = 1'b0;
    tick();
    chk_ctl("rm.done", ST_DONE, 1'b0, 1'b0, 1'b1);
    chk("rm.instr2", instr_out, 16'h00C3);
    chk("rm.pc", pc_in, 16'h0022);
    tick();

    // en held high: exactly one IDLE cycle between the two valid pulses.
    en = 1'b1; mem_ack = 1'b1; mem_data_in = 16'h0011;
    tick();
    chk_ctl("bb.f1a", ST_FETCH1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_ctl("bb.inc1a", ST_INC1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_ctl("bb.donea", ST_DONE, 1'b0, 1'b0, 1'b1);
    tick();
    chk_ctl("bb.idle", ST_IDLE, 1'b0, 1'b0, 1'b0);
    tick();
    chk_ctl("bb.f1b", ST_FETCH1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk_ctl("bb.doneb", ST_DONE, 1'b0, 1'b0, 1'b1);
    en = 1'b0; mem_ack = 1'b0;
    tick();

    // Flush beats en in IDLE, and an ack in IDLE is ignored.
    en = 1'b1; flush = 1'b1; mem_ack = 1'b1; mem_data_in = 16'hABCD;
    tick();
    en = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    chk_ctl("fidle", ST_IDLE, 1'b0, 1'b0, 1'b0);
    chk("fidle.instr", instr_out, 16'h0011);
    chk("fidle.addr", mem_addr, pc_in);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have port: en  input  1  fetch request; sampled only in IDLE.
REQ-004 SHALL have port: flush  input  1  abort in-flight fetch (branch taken / pipeline clear).
REQ-005 SHALL have port: pc_in  input  16  current PC from the PC unit's pc_out.
REQ-006 SHALL have port: mem_data_in  input  16  read data from the instruction memory port.
REQ-007 SHALL have port: mem_ack  input  1  read complete; mem_data_in valid this cycle.
REQ-008 SHALL have port: mem_addr  output  16  read address; combinationally equal to pc_in.
REQ-009 SHALL have port: mem_rd  output  1  read request; high in FETCH1/FETCH2 only.
REQ-010 SHALL have port: pc_en  output  1  enable to the PC unit.
REQ-011 SHALL have port: pc_op  output  2  PC operation to the PC unit, using the PC_NOP/PC_INC encodings from the shared CPU constants header.
REQ-012 SHALL have port: instr_out  output  16  latched first instruction word.
REQ-013 SHALL have port: imm_out  output  16  latched second (immediate) word.
REQ-014 SHALL have port: has_imm  output  1  instr_out[8] of the current instruction; imm_out valid.
REQ-015 SHALL have port: valid  output  1  one-cycle pulse; instruction fetch complete.

Function
REQ-016 SHALL implement states IDLE, FETCH1, INC1, FETCH2, INC2, DONE in a registered FSM.
REQ-017 IDLE: en=1 -> FETCH1; else stay; mem_rd=0, pc_en=0.
REQ-018 FETCH1: mem_rd=1; on mem_ack latch instr_out<=mem_data_in, has_imm<=mem_data_in[8], go INC1; no ack -> stay, unbounded wait.
REQ-019 INC1: pc_en=1, pc_op=PC_INC for exactly one cycle; next FETCH2 if has_imm=1, else DONE.
REQ-020 FETCH2: mem_rd=1; address is the post-increment pc_in; on mem_ack latch imm_out<=mem_data_in, go INC2.
REQ-021 INC2: pc_en=1, pc_op=PC_INC for one cycle; next DONE.
REQ-022 DONE: valid=1 for exactly one cycle; next IDLE regardless of en.
REQ-023 In all states other than INC1/INC2, pc_en SHALL be 0 and pc_op SHALL be PC_NOP.
REQ-024 mem_rd, pc_en, pc_op and valid SHALL be decoded from state only (Moore); mem_addr is the only combinational input-to-output path.
REQ-025 Minimum latency (mem_ack high in the first FETCH cycle): en in IDLE at cycle 0 -> valid at cycle 3 (one word) or cycle 5 (two words).
REQ-026 In single-word instructions imm_out SHALL hold its previous value.
REQ-027 instr_out, imm_out and has_imm SHALL hold stable from their capture until the next capture or reset.
REQ-028 flush=1 in any state SHALL force next state IDLE, with priority over mem_ack and en; valid is not produced.
REQ-029 flush=1 in INC1/INC2 SHALL still drive pc_en=1/PC_INC that cycle (Moore outputs); the PC increment completes and the instruction is discarded.
REQ-030 flush=1 coincident with mem_ack in FETCH1/FETCH2 SHALL NOT update instr_out/imm_out/has_imm.
REQ-031 mem_ack outside FETCH1/FETCH2 SHALL be ignored.
REQ-032 PC is advanced by the PC unit only (+2 per word); this block SHALL perform no address arithmetic.

Reset
REQ-033 rst=1 SHALL force state IDLE, instr_out=0, imm_out=0, has_imm=0, valid=0, mem_rd=0, pc_en=0, pc_op=PC_NOP, and SHALL override flush, en and mem_ack.
REQ-034 rst asserted mid-fetch (any state) SHALL abandon the fetch with no valid pulse and no further pc_en.

Verification
REQ-035 Single word: pc_in=0x0000, en pulse, mem_ack immediate, data 0x1234 -> one PC_INC pulse, valid at cycle 3, instr_out=0x1234, has_imm=0.
REQ-036 Two words: data 0x0100 at 0x0000, then 0xBEEF at 0x0002 -> mem_addr 0x0000 then 0x0002, two PC_INC pulses, valid at cycle 5, imm_out=0xBEEF, has_imm=1.
REQ-037 Wait states: mem_ack delayed 4 cycles in FETCH1 -> mem_rd held high 5 cycles, no pc_en until ack, valid 4 cycles later than the REQ-035 case.
REQ-038 Flush: flush with mem_ack in FETCH1, data 0x5555 -> IDLE next cycle, instr_out unchanged, no valid, no PC_INC.
REQ-039 Reset mid-fetch: rst in FETCH2 -> next cycle all outputs at reset values, state IDLE; subsequent en fetches normally.
REQ-040 Back-to-back: en held high continuously -> DONE->IDLE->FETCH1, exactly one idle cycle between valid pulses.
